// File: rtl/de1_soc.sv
`timescale 1ns/1ps
// de1_soc: DE1-SoC top generating 640x480@60 VGA test patterns, a frame counter on the
// seven-segment displays and switch mirroring on the LEDs.
module de1_soc #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clock_50,
    input  logic [3:0] key,
    input  logic [9:0] sw,
    output logic [9:0] ledr,
    output logic [6:0] hex0,
    output logic [6:0] hex1,
    output logic [6:0] hex2,
    output logic [6:0] hex3,
    output logic [6:0] hex4,
    output logic [6:0] hex5,
    output logic       VGA_CLK,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_BLANK,
    output logic       VGA_SYNC,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam logic [9:0] H_MAX  = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX  = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
    localparam logic [9:0] HS_ON  = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_OFF = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_ON  = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_OFF = 10'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam int BAR_W = H_VISIBLE / 8;
    // {R,G,B} per bar, bar 0 in the low bits: white, yellow, cyan, green, magenta, red, blue, black
    localparam logic [23:0] BAR_LUT = {3'b000, 3'b001, 3'b100, 3'b101,
                                       3'b010, 3'b011, 3'b110, 3'b111};

    logic        rst;
    logic        tick;
    logic        h_end;
    logic        v_end;
    logic        visible;
    logic        hs_n;
    logic        vs_n;
    logic [2:0]  bar;
    logic [2:0]  pix;
    logic [9:0]  hcount;
    logic [9:0]  vcount;
    logic [23:0] frame;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: glyph = 7'b1000000;
            4'h1: glyph = 7'b1111001;
            4'h2: glyph = 7'b0100100;
            4'h3: glyph = 7'b0110000;
            4'h4: glyph = 7'b0011001;
            4'h5: glyph = 7'b0010010;
            4'h6: glyph = 7'b0000010;
            4'h7: glyph = 7'b1111000;
            4'h8: glyph = 7'b0000000;
            4'h9: glyph = 7'b0010000;
            4'hA: glyph = 7'b0001000;
            4'hB: glyph = 7'b0000011;
            4'hC: glyph = 7'b1000110;
            4'hD: glyph = 7'b0100001;
            4'hE: glyph = 7'b0000110;
            default: glyph = 7'b0001110;
        endcase
    endfunction

    assign rst      = ~key[0];
    assign tick     = VGA_CLK;
    assign h_end    = hcount == H_MAX;
    assign v_end    = vcount == V_MAX;
    assign VGA_SYNC = 1'b0;
    assign ledr     = {sw[9:1], vcount < V_VIS};
    assign hex0     = glyph(frame[3:0]);
    assign hex1     = glyph(frame[7:4]);
    assign hex2     = glyph(frame[11:8]);
    assign hex3     = glyph(frame[15:12]);
    assign hex4     = glyph(frame[19:16]);
    assign hex5     = glyph(frame[23:20]);

    // The toggle is the pixel clock; counters advance when it is high, so VGA_CLK falls as they move.
    always_ff @(posedge clock_50 or posedge rst) begin
        if (rst)
            VGA_CLK <= 1'b0;
        else
            VGA_CLK <= ~VGA_CLK;
    end

    always_ff @(posedge clock_50 or posedge rst) begin
        if (rst) begin
            hcount <= '0;
            vcount <= '0;
        end else if (tick) begin
            hcount <= h_end ? '0 : hcount + 10'd1;
            if (h_end)
                vcount <= v_end ? '0 : vcount + 10'd1;
        end
    end

    always_comb begin
        visible = hcount < H_VIS && vcount < V_VIS;
        hs_n    = !(hcount >= HS_ON && hcount < HS_OFF);
        vs_n    = !(vcount >= VS_ON && vcount < VS_OFF);
        bar     = '0;
        for (int i = 1; i < 8; i++)
            if (hcount >= 10'(i * BAR_W))
                bar = 3'(i);
        pix = (!visible || !key[3]) ? 3'b000 :
              !key[2] ? {3{~(hcount[5] ^ vcount[5])}} :
              BAR_LUT[5'(bar) * 5'd3 +: 3];
    end

    always_ff @(posedge clock_50 or posedge rst) begin
        if (rst) begin
            VGA_HS    <= 1'b1;
            VGA_VS    <= 1'b1;
            VGA_BLANK <= 1'b0;
            VGA_R     <= '0;
            VGA_G     <= '0;
            VGA_B     <= '0;
        end else if (tick) begin
            VGA_HS    <= hs_n;
            VGA_VS    <= vs_n;
            VGA_BLANK <= visible;
            VGA_R     <= {8{pix[2]}};
            VGA_G     <= {8{pix[1]}};
            VGA_B     <= {8{pix[0]}};
        end
    end

    always_ff @(posedge clock_50 or posedge rst) begin
        if (rst)
            frame <= '0;
        else if (!key[1])
            frame <= '0;
        else if (tick && h_end && v_end && sw[0])
            frame <= frame + 24'd1;
    end
endmodule

// File: tb/tb_de1_soc.sv
`timescale 1ns/1ps
// tb_de1_soc: scoreboard bench; stimulus pushes expectations, negedge monitors pop and compare.
module tb_de1_soc;
    typedef struct {string name; int v; int h; logic [23:0] rgb;} pix_t;
    typedef struct {string name; int sel; logic [63:0] want;} chk_t;
    typedef struct {int bw; int hofs; int hw; int per;} line_t;
    typedef struct {int w; int ofs; int per;} vs_t;

    logic clock_50 = 1'b0;
    always #5 clock_50 = ~clock_50;

    logic [3:0] key, key2;
    logic [9:0] sw, sw2;
    logic [9:0] ledr, ledr2;
    logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;
    logic [6:0] g0, g1, g2, g3, g4, g5;
    logic       VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK, VGA_SYNC;
    logic [7:0] VGA_R, VGA_G, VGA_B;
    logic       clk2, hs2, vs2, bl2, sync2;
    logic [7:0] r2, gr2, b2;

    de1_soc dut (
        .clock_50(clock_50), .key(key), .sw(sw), .ledr(ledr),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5),
        .VGA_CLK(VGA_CLK), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK(VGA_BLANK),
        .VGA_SYNC(VGA_SYNC), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
    );

    // Shrunken timing so whole frames fit in a short run: 24 ticks x 10 lines.
    de1_soc #(
        .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(2),
        .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
    ) dut2 (
        .clock_50(clock_50), .key(key2), .sw(sw2), .ledr(ledr2),
        .hex0(g0), .hex1(g1), .hex2(g2), .hex3(g3), .hex4(g4), .hex5(g5),
        .VGA_CLK(clk2), .VGA_HS(hs2), .VGA_VS(vs2), .VGA_BLANK(bl2),
        .VGA_SYNC(sync2), .VGA_R(r2), .VGA_G(gr2), .VGA_B(b2)
    );

    int n_tests = 0;
    int n_fail = 0;
    pix_t  pix_q[$];
    chk_t  chk_q[$];
    line_t line_q[$];
    vs_t   vs_q[$];
    bit done_a = 0, done_b = 0;

    localparam logic [6:0] G0 = 7'b1000000;
    localparam logic [6:0] G3 = 7'b0110000;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // main monitor state
    int cyc = 0, ln = 0, px = 0, viol = 0;
    int t_br = -1, t_bf = -1, t_hf = -1, per = 0;
    logic hs_p = 1'b1, bl_p = 1'b0;
    longint t_clk = -1, clkp = 0;
    pix_t p;
    chk_t c;
    line_t lt;

    function automatic logic [63:0] obs(input int sel);
        case (sel)
            0: obs = 64'({VGA_HS, VGA_VS, VGA_BLANK, VGA_R, VGA_G, VGA_B});
            1: obs = 64'({hex5, hex4, hex3, hex2, hex1, hex0});
            2: obs = 64'(ledr);
            3: obs = 64'({g5, g4, g3, g2, g1, g0});
            4: obs = 64'(clkp);
            5: obs = 64'(viol);
            6: obs = 64'(VGA_CLK);
            7: obs = 64'(VGA_SYNC);
            default: obs = '0;
        endcase
    endfunction

    always @(posedge VGA_CLK) begin
        if (t_clk >= 0) clkp = $time - t_clk;
        t_clk = $time;
    end

    always @(negedge clock_50) begin
        cyc++;
        if (!key[0]) begin
            ln = 0; px = 0; t_hf = -1; per = 0;
        end else begin
            if (!bl_p && VGA_BLANK) t_br = cyc;
            if (bl_p && !VGA_BLANK) begin t_bf = cyc; ln++; end
            if (hs_p && !VGA_HS) begin
                if (t_hf >= 0) per = cyc - t_hf;
                t_hf = cyc;
            end
            if (!hs_p && VGA_HS && per > 0 && line_q.size() > 0) begin
                lt = line_q.pop_front();
                check("blank_width", 64'(t_bf - t_br), 64'(lt.bw));
                check("hs_offset", 64'(t_hf - t_br), 64'(lt.hofs));
                check("hs_width", 64'(cyc - t_hf), 64'(lt.hw));
                check("line_period", 64'(per), 64'(lt.per));
            end
            if (!VGA_BLANK) begin
                px = 0;
                if ({VGA_R, VGA_G, VGA_B} != 24'h0) viol++;
            end else if (VGA_CLK) begin
                if (pix_q.size() > 0) begin
                    if (pix_q[0].v == ln && pix_q[0].h == px) begin
                        p = pix_q.pop_front();
                        check(p.name, 64'({VGA_R, VGA_G, VGA_B}), 64'(p.rgb));
                    end else if (ln > pix_q[0].v || (ln == pix_q[0].v && px > pix_q[0].h)) begin
                        p = pix_q.pop_front();
                        n_tests++; n_fail++;
                        $display("FAIL %s: pixel never seen, got none want %0h", p.name, p.rgb);
                    end
                end
                px++;
            end
        end
        while (chk_q.size() > 0) begin
            c = chk_q.pop_front();
            check(c.name, obs(c.sel), c.want);
        end
        hs_p = VGA_HS;
        bl_p = VGA_BLANK;
    end

    // small-instance frame monitor
    int t_fs = -1, t_vf = -1, t_vfp = -1;
    bit fs_arm = 1;
    logic vs2_p = 1'b1, bl2_p = 1'b0;
    vs_t vt;
    always @(negedge clock_50) begin
        if (!key2[0]) begin
            t_fs = -1; t_vf = -1; t_vfp = -1; fs_arm = 1;
        end else begin
            if (!bl2_p && bl2 && fs_arm) begin t_fs = cyc; fs_arm = 0; end
            if (vs2_p && !vs2) begin t_vfp = t_vf; t_vf = cyc; end
            if (!vs2_p && vs2) begin
                if (t_vfp >= 0 && t_fs >= 0 && vs_q.size() > 0) begin
                    vt = vs_q.pop_front();
                    check("vs_width", 64'(cyc - t_vf), 64'(vt.w));
                    check("vs_offset", 64'(t_vf - t_fs), 64'(vt.ofs));
                    check("frame_period", 64'(t_vf - t_vfp), 64'(vt.per));
                end
                fs_arm = 1;
            end
        end
        vs2_p = vs2;
        bl2_p = bl2;
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clock_50);
        #1;
    endtask

    task automatic push_pix(input string name, input int v, input int h, input logic [23:0] rgb);
        pix_q.push_back('{name, v, h, rgb});
    endtask

    task automatic push_chk(input string name, input int sel, input logic [63:0] want);
        chk_q.push_back('{name, sel, want});
    endtask

    task automatic wait_pix(input int limit, input string name);
        int k = 0;
        while (pix_q.size() > 0 && k < limit) begin cycles(1); k++; end
        if (pix_q.size() > 0) begin
            n_tests++; n_fail++;
            $display("FAIL %s: timeout, got %0d pending want 0", name, pix_q.size());
            pix_q.delete();
        end
    endtask

    initial begin
        int k;
        key = 4'b1110;
        sw  = 10'h000;
        cycles(5);
        push_chk("reset_sync_rgb", 0, 64'({1'b1, 1'b1, 1'b0, 24'h0}));
        push_chk("reset_hex", 1, 64'({6{G0}}));
        push_chk("reset_vga_clk", 6, 64'd0);
        push_chk("vga_sync", 7, 64'd0);
        cycles(1);
        repeat (3) line_q.push_back('{1280, 1312, 192, 1600});
        push_pix("bar_white_0", 0, 0, 24'hFFFFFF);
        push_pix("bar_yellow_80", 0, 80, 24'hFFFF00);
        push_pix("bar_cyan_160", 0, 160, 24'h00FFFF);
        push_pix("bar_green_240", 0, 240, 24'h00FF00);
        push_pix("bar_magenta_320", 0, 320, 24'hFF00FF);
        push_pix("bar_red_400", 0, 400, 24'hFF0000);
        push_pix("bar_blue_480", 0, 480, 24'h0000FF);
        push_pix("bar_black_639", 0, 639, 24'h000000);
        push_pix("bar_edge_79", 1, 79, 24'hFFFFFF);
        key = 4'b1111;
        sw  = 10'h2AA;
        cycles(20);
        push_chk("ledr", 2, 64'h2AB);
        push_chk("vga_clk_period", 4, 64'd20);
        wait_pix(5000, "bars");
        key = 4'b1011;
        push_pix("chk_l2_p0", 2, 0, 24'hFFFFFF);
        push_pix("chk_l2_p31", 2, 31, 24'hFFFFFF);
        push_pix("chk_l2_p32", 2, 32, 24'h000000);
        push_pix("chk_l2_p64", 2, 64, 24'hFFFFFF);
        push_pix("chk_l32_p0", 32, 0, 24'h000000);
        push_pix("chk_l32_p32", 32, 32, 24'hFFFFFF);
        wait_pix(60000, "checker");
        key = 4'b0011;
        push_pix("black_l33_p32", 33, 32, 24'h000000);
        push_pix("black_l34_p100", 34, 100, 24'h000000);
        wait_pix(5000, "black");
        push_chk("rgb_zero_in_blank", 5, 64'd0);
        k = 0;
        while (px < 300 && k < 4000) begin cycles(1); k++; end
        if (px < 300) begin
            n_tests++; n_fail++;
            $display("FAIL mid_line_wait: got px %0d want 300", px);
        end
        key[0] = 1'b0;
        push_chk("async_reset_sync_rgb", 0, 64'({1'b1, 1'b1, 1'b0, 24'h0}));
        push_chk("async_reset_vga_clk", 6, 64'd0);
        cycles(3);
        key = 4'b1111;
        cycles(2);
        done_a = 1;
    end

    initial begin
        key2 = 4'b1110;
        sw2  = 10'h001;
        repeat (3) vs_q.push_back('{96, 336, 480});
        cycles(3);
        key2 = 4'b1111;
        cycles(1600);
        push_chk("frames_3", 3, 64'({{5{G0}}, G3}));
        sw2 = 10'h000;
        cycles(1000);
        push_chk("frames_hold", 3, 64'({{5{G0}}, G3}));
        key2 = 4'b1101;
        cycles(2);
        key2 = 4'b1111;
        cycles(1);
        push_chk("frames_clear", 3, 64'({6{G0}}));
        cycles(2);
        done_b = 1;
    end

    initial begin
        wait (done_a && done_b);
        if (line_q.size() > 0) begin
            n_tests++; n_fail++;
            $display("FAIL line_timing: got %0d unmeasured want 0", line_q.size());
        end
        if (vs_q.size() > 0) begin
            n_tests++; n_fail++;
            $display("FAIL frame_timing: got %0d unmeasured want 0", vs_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
